// File: rtl/stv_aes_pkg.sv
// Shared AES types and GF(2^8) helpers for the round datapath.
// State layout is column-major: byte index 4*c + r holds row r of column c.
package stv_aes_pkg;

  localparam logic [7:0] AES_POLY = 8'h1B;

  typedef logic [15:0][7:0] aes_state_t;
  typedef logic [3:0][7:0]  aes_col_t;

  function automatic logic [7:0] gf_xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
  endfunction

  // Multiply by a small constant (only the low nibble matters for the MixColumns coefficients)
  function automatic logic [7:0] gf_mul(input logic [7:0] b, input logic [3:0] m);
    logic [7:0] acc;
    logic [7:0] p;
    acc = 8'h00;
    p   = b;
    for (int i = 0; i < 4; i++) begin
      if (m[i]) acc = acc ^ p;
      p = gf_xtime(p);
    end
    return acc;
  endfunction

endpackage

// File: rtl/stv_aes_mixcolumn.sv
// Combinational single-column MixColumns / InvMixColumns.
module stv_aes_mixcolumn
  import stv_aes_pkg::*;
(
  input  logic [3:0][7:0] col_in,
  input  logic            inverse,
  output logic [3:0][7:0] col_out
);

  aes_col_t w_fwd;
  aes_col_t w_inv;

  // Row r uses the base coefficient row rotated right by r
  for (genvar gi = 0; gi < 4; gi++) begin : g_row
    assign w_fwd[gi] = gf_mul(col_in[gi], 4'h2)
                     ^ gf_mul(col_in[(gi + 1) % 4], 4'h3)
                     ^ col_in[(gi + 2) % 4]
                     ^ col_in[(gi + 3) % 4];
    assign w_inv[gi] = gf_mul(col_in[gi], 4'he)
                     ^ gf_mul(col_in[(gi + 1) % 4], 4'hb)
                     ^ gf_mul(col_in[(gi + 2) % 4], 4'hd)
                     ^ gf_mul(col_in[(gi + 3) % 4], 4'h9);
    assign col_out[gi] = inverse ? w_inv[gi] : w_fwd[gi];
  end

endmodule

// File: rtl/stv_aes_mixcolumns_iter.sv
// Iterative MixColumns stage: COLS_PER_CYCLE columns per clock, valid/ready on both sides.
module stv_aes_mixcolumns_iter
  import stv_aes_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 1
)
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [15:0][7:0] data_in,
  input  logic            inverse,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [15:0][7:0] data_out
);

  if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
    $error("stv_aes_mixcolumns_iter: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  localparam int         NUM_STEPS = 4 / COLS_PER_CYCLE;
  localparam logic [1:0] LAST_STEP = 2'(NUM_STEPS - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} fsm_t;

  fsm_t       r_fsm;
  logic [1:0] r_step;
  aes_state_t r_work;
  logic       r_inverse;

  logic [1:0]      w_base;
  logic [1:0]      w_col_idx [COLS_PER_CYCLE];
  logic [3:0][7:0] w_col_in  [COLS_PER_CYCLE];
  logic [3:0][7:0] w_col_out [COLS_PER_CYCLE];

  assign w_base = 2'(32'(r_step) * COLS_PER_CYCLE);

  for (genvar gi = 0; gi < COLS_PER_CYCLE; gi++) begin : g_col
    assign w_col_idx[gi] = w_base + 2'(gi);
    assign w_col_in[gi]  = {r_work[{w_col_idx[gi], 2'd3}], r_work[{w_col_idx[gi], 2'd2}],
                            r_work[{w_col_idx[gi], 2'd1}], r_work[{w_col_idx[gi], 2'd0}]};

    stv_aes_mixcolumn u_mixcolumn (
      .col_in  (w_col_in[gi]),
      .inverse (r_inverse),
      .col_out (w_col_out[gi])
    );
  end

  // A finished result can be retired and a new state taken on the same edge
  assign in_ready  = (r_fsm == IDLE) || ((r_fsm == DONE) && out_ready);
  assign out_valid = (r_fsm == DONE);
  assign data_out  = r_work;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_fsm     <= IDLE;
      r_step    <= 2'd0;
      r_work    <= '0;
      r_inverse <= 1'b0;
    end else begin
      case (r_fsm)
        IDLE: begin
          if (in_valid) begin
            r_work    <= data_in;
            r_inverse <= inverse;
            r_step    <= 2'd0;
            r_fsm     <= BUSY;
          end
        end
        BUSY: begin
          for (int j = 0; j < COLS_PER_CYCLE; j++) begin
            for (int r = 0; r < 4; r++) begin
              r_work[{w_col_idx[j], 2'(r)}] <= w_col_out[j][r];
            end
          end
          if (r_step == LAST_STEP) begin
            r_step <= 2'd0;
            r_fsm  <= DONE;
          end else begin
            r_step <= r_step + 2'd1;
          end
        end
        DONE: begin
          if (out_ready) begin
            if (in_valid) begin
              r_work    <= data_in;
              r_inverse <= inverse;
              r_step    <= 2'd0;
              r_fsm     <= BUSY;
            end else begin
              r_fsm <= IDLE;
            end
          end
        end
        default: r_fsm <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stv_aes_mixcolumns_iter.sv
// Self-checking bench: three instances (1, 2, 4 columns per cycle) against a matrix-level GF model.
module tb_stv_aes_mixcolumns_iter;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid_a  [3];
  logic            in_ready_a  [3];
  logic [15:0][7:0] data_in_a  [3];
  logic            inverse_a   [3];
  logic            out_valid_a [3];
  logic            out_ready_a [3];
  logic [15:0][7:0] data_out_a [3];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    stv_aes_mixcolumns_iter #(.COLS_PER_CYCLE(1 << gi)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid_a[gi]),
      .in_ready  (in_ready_a[gi]),
      .data_in   (data_in_a[gi]),
      .inverse   (inverse_a[gi]),
      .out_valid (out_valid_a[gi]),
      .out_ready (out_ready_a[gi]),
      .data_out  (data_out_a[gi])
    );
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Shift-and-add GF(2^8) multiply modulo x^8+x^4+x^3+x+1
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    logic [7:0] y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
      y = y >> 1;
    end
    return p;
  endfunction

  // Matrix product of the circulant (02 03 01 01) or (0e 0b 0d 09) with each column
  function automatic logic [127:0] ref_mix(input logic [127:0] st, input logic inv);
    logic [15:0][7:0] s;
    logic [15:0][7:0] o;
    logic [7:0] base [4];
    logic [7:0] acc;
    s = st;
    if (inv) base = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    else     base = '{8'h02, 8'h03, 8'h01, 8'h01};
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int k = 0; k < 4; k++) acc = acc ^ gmul(s[4*c + k], base[(k - r + 4) % 4]);
        o[4*c + r] = acc;
      end
    end
    return o;
  endfunction

  // Build a state from four column words written top row first
  function automatic logic [127:0] mk(input logic [31:0] c0, input logic [31:0] c1,
                                      input logic [31:0] c2, input logic [31:0] c3);
    logic [15:0][7:0] s;
    logic [31:0] cols [4];
    cols = '{c0, c1, c2, c3};
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) s[4*c + r] = cols[c][31 - 8*r -: 8];
    return s;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic run_op(input int k, input logic [127:0] st, input logic inv, input bit toggle,
                        output logic [127:0] res);
    int cyc;
    @(negedge clk);
    data_in_a[k] = st; inverse_a[k] = inv; in_valid_a[k] = 1'b1; out_ready_a[k] = 1'b0;
    #1 chk("in_ready_idle", 128'(in_ready_a[k]), 128'd1);
    @(negedge clk);
    in_valid_a[k] = 1'b0; data_in_a[k] = rnd128();
    cyc = 1;
    while (!out_valid_a[k] && cyc < 20) begin
      if (toggle) inverse_a[k] = ~inverse_a[k];
      @(negedge clk);
      cyc++;
    end
    chk("latency", 128'(cyc), 128'((4 >> k) + 1));
    res = data_out_a[k];
    out_ready_a[k] = 1'b1;
    @(negedge clk);
    out_ready_a[k] = 1'b0;
    chk("valid_drop_after_hs", 128'(out_valid_a[k]), 128'd0);
    $display("[TB] inst %0d op inv=%0d in=%h out=%h latency=%0d", k, inv, st, res, cyc);
  endtask

  task automatic backpressure(input int k);
    logic [127:0] st1, st2, res;
    int cyc;
    st1 = rnd128(); st2 = rnd128();
    @(negedge clk);
    data_in_a[k] = st1; inverse_a[k] = 1'b0; in_valid_a[k] = 1'b1; out_ready_a[k] = 1'b0;
    @(negedge clk);
    in_valid_a[k] = 1'b0;
    cyc = 1;
    while (!out_valid_a[k] && cyc < 20) begin @(negedge clk); cyc++; end
    data_in_a[k] = st2; inverse_a[k] = 1'b1; in_valid_a[k] = 1'b1;
    #1 chk("bp_in_ready_low", 128'(in_ready_a[k]), 128'd0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_valid_hold", 128'(out_valid_a[k]), 128'd1);
      chk("bp_data_hold", data_out_a[k], ref_mix(st1, 1'b0));
      chk("bp_in_ready", 128'(in_ready_a[k]), 128'd0);
    end
    out_ready_a[k] = 1'b1;
    #1 chk("bp_in_ready_hs", 128'(in_ready_a[k]), 128'd1);
    @(negedge clk);
    out_ready_a[k] = 1'b0; in_valid_a[k] = 1'b0;
    chk("bp_busy_after_hs", 128'(out_valid_a[k]), 128'd0);
    cyc = 1;
    while (!out_valid_a[k] && cyc < 20) begin @(negedge clk); cyc++; end
    chk("bp_latency2", 128'(cyc), 128'((4 >> k) + 1));
    res = data_out_a[k];
    chk("bp_data2", res, ref_mix(st2, 1'b1));
    out_ready_a[k] = 1'b1;
    @(negedge clk);
    out_ready_a[k] = 1'b0;
    $display("[TB] inst %0d backpressure second result=%h", k, res);
  endtask

  task automatic rand_test(input int k, input int n);
    logic [127:0] exp_q[$];
    logic [127:0] prev_data;
    bit prev_hold;
    int sent, recvd, cyc;
    sent = 0; recvd = 0; cyc = 0; prev_hold = 0; prev_data = '0;
    while ((sent < n || recvd < sent) && cyc < 12 * n + 100) begin
      @(negedge clk);
      cyc++;
      if (prev_hold) begin
        chk("rand_valid_hold", 128'(out_valid_a[k]), 128'd1);
        chk("rand_data_hold", data_out_a[k], prev_data);
      end
      in_valid_a[k]  = (sent < n) && ($urandom_range(0, 3) != 0);
      data_in_a[k]   = rnd128();
      inverse_a[k]   = 1'($urandom_range(0, 1));
      out_ready_a[k] = (sent >= n) || ($urandom_range(0, 2) != 0);
      #1;
      if (out_valid_a[k] && out_ready_a[k]) begin
        if (exp_q.size() == 0) chk("rand_spurious", 128'd1, 128'd0);
        else begin
          chk("rand_data", data_out_a[k], exp_q.pop_front());
          recvd++;
        end
      end
      if (in_valid_a[k] && in_ready_a[k]) begin
        exp_q.push_back(ref_mix(data_in_a[k], inverse_a[k]));
        sent++;
      end
      prev_hold = out_valid_a[k] && !out_ready_a[k];
      prev_data = data_out_a[k];
    end
    @(negedge clk);
    in_valid_a[k] = 1'b0; out_ready_a[k] = 1'b0;
    chk("rand_sent", 128'(sent), 128'(n));
    chk("rand_recvd", 128'(recvd), 128'(n));
    $display("[TB] inst %0d random: %0d sent %0d received in %0d cycles", k, sent, recvd, cyc);
  endtask

  initial begin
    logic [127:0] res, v2, v2_out, kat_in, kat_out;
    int cyc;
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid_a[k] = 1'b0; out_ready_a[k] = 1'b0; inverse_a[k] = 1'b0; data_in_a[k] = '0;
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("rst_out_valid", 128'(out_valid_a[k]), 128'd0);
      chk("rst_in_ready", 128'(in_ready_a[k]), 128'd1);
      chk("rst_data_out", data_out_a[k], 128'd0);
    end

    kat_in  = mk(32'hdb135345, 32'hdb135345, 32'hdb135345, 32'hdb135345);
    kat_out = mk(32'h8e4da1bc, 32'h8e4da1bc, 32'h8e4da1bc, 32'h8e4da1bc);
    v2      = mk(32'hf20a225c, 32'h01010101, 32'hc6c6c6c6, 32'hd4d4d4d5);
    v2_out  = mk(32'h9fdc589d, 32'h01010101, 32'hc6c6c6c6, 32'hd5d5d7d6);

    for (int k = 0; k < 3; k++) begin
      run_op(k, kat_in, 1'b0, 1'b0, res);
      chk("kat_fwd", res, kat_out);
      run_op(k, v2, 1'b0, 1'b0, res);
      chk("vec_fwd", res, v2_out);
      run_op(k, v2_out, 1'b1, 1'b1, res);
      chk("vec_inv_toggle", res, v2);
      run_op(k, kat_out, 1'b1, 1'b0, res);
      chk("kat_inv", res, kat_in);
      backpressure(k);
    end

    // Reset while instance 0 is at step 2 of BUSY
    @(negedge clk);
    data_in_a[0] = v2; inverse_a[0] = 1'b0; in_valid_a[0] = 1'b1;
    @(negedge clk);
    in_valid_a[0] = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst_out_valid", 128'(out_valid_a[0]), 128'd0);
    chk("midrst_data_out", data_out_a[0], 128'd0);
    chk("midrst_in_ready", 128'(in_ready_a[0]), 128'd1);
    run_op(0, v2, 1'b0, 1'b0, res);
    chk("midrst_after", res, v2_out);

    rand_test(0, 1000);
    rand_test(1, 300);
    rand_test(2, 300);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
